lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Multi-cycle load/store initiator sitting between the RV32I core's execute stage and the word-wide data memory.
- Core side: decodes funct3, checks alignment and range, and sign/zero-extends byte and halfword loads.
- Memory side: drives the word-addressed data memory, which has a combinational read (re), a write on posedge (we), and no byte enables.
- Sub-word stores therefore run as read-modify-write.

Parameters:
- MEM_WORDS, 8192, number of 32-bit words in data memory; byte address >= MEM_WORDS*4 is out of range.
- ADDR_W, 32, core address width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  core requests an access
- req_ready  out  1  high only in IDLE; request accepted when req_valid&&req_ready at posedge
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data (low bits used for B/H)
- resp_valid  out  1  one-cycle pulse, access complete
- resp_err  out  1  qualified by resp_valid: misaligned, illegal funct3, or out of range
- resp_rdata  out  32  extended load data; 0 for stores and errors; held until next resp_valid
- mem_addr  out  32  {addr[31:2],2'b00}
- mem_wdata  out  32  word to write
- mem_we  out  1  memory write enable; memory commits on posedge
- mem_re  out  1  memory read enable
- mem_rdata  in  32  memory read data, combinational from mem_addr while mem_re=1

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; resp_valid, resp_err, mem_we, mem_re = 0.
  - resp_rdata, mem_addr, mem_wdata and the latched request fields = 0.
  - Takes effect immediately mid-operation. mem_we drops before the next edge, so no partial or merged write occurs. Any in-flight response is discarded.
- On accept:
  - addr, we, funct3 and wdata are latched.
  - Later changes on req_* are ignored until the next IDLE.
  - req_valid outside IDLE is ignored, with no queuing.
- Error check at accept:
  - Illegal: funct3 in {011,110,111}, or a store with funct3 in {100,101}.
  - Misaligned: H/HU with addr[0]!=0, or W with addr[1:0]!=0.
  - Out of range: addr >= MEM_WORDS*4.
  - Any error -> RESP with resp_err=1, with no mem_re or mem_we ever asserted.
- States (Moore; mem_re and mem_we are decoded from state):
  - IDLE: req_ready=1.
    - Error -> RESP.
    - Load or SB/SH -> READ.
    - SW -> WRITE, with mem_wdata=wdata.
  - READ: mem_re=1.
    - Load: extract the lane, extend, register into resp_rdata -> RESP.
    - SB/SH: merge the new lane into mem_rdata, register into mem_wdata -> WRITE.
  - WRITE: mem_we=1 for exactly one cycle -> RESP.
  - RESP: resp_valid=1 for one cycle -> IDLE. req_ready is 0 here.
- Lanes are little-endian: byte k = [8k+7:8k], half at addr[1]=1 is [31:16].
  - B/H loads sign-extend; BU/HU zero-extend.
  - SB replaces only byte addr[1:0]; SH replaces only half addr[1]. Other bytes are preserved.
- Latency from the accept edge to resp_valid high:
  - Error: 1 cycle.
  - Load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
- Back-to-back throughput: the next accept is possible in the cycle after RESP.
- resp_err=0 whenever resp_valid=0.

Test Plan:
- Preload word 0x100 = 0x8899AABB:
  - LB 0x101 -> resp_rdata 0xFFFFFFAA, 2 cycles.
  - LBU 0x101 -> 0x000000AA.
  - LH 0x102 -> 0xFFFF8899.
  - LHU 0x100 -> 0x0000AABB.
- SB 0x103 wdata 0x12345678 -> one mem_re cycle, then one mem_we cycle with mem_wdata 0x7899AABB. resp_valid at cycle 3. Follow-up LW 0x100 returns 0x7899AABB.
- SW 0x104 wdata 0xDEADBEEF -> mem_re never high, mem_we high one cycle at mem_addr 0x104, resp_valid at cycle 2. LW 0x104 returns 0xDEADBEEF.
- Error cases, each with resp_err=1 at cycle 1, resp_rdata 0, and mem_re/mem_we never high:
  - LW 0x102.
  - SH 0x101.
  - funct3 011.
  - LW 0x8000 with MEM_WORDS=8192.
- Reset during an SB to 0x100 word 0x8899AABB: pull rst_n low while in WRITE, before the edge -> mem_we low immediately, memory word still 0x8899AABB, no resp_valid, req_ready=1 after release.
- Handshake: req_valid held high with changing addr during a busy load -> only the first request is serviced. The second is accepted in the cycle after RESP with its then-current fields.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl
// Purpose  : Multi-cycle RV32I load/store initiator in front of a word-wide
//            data memory with combinational read and no byte enables.
//            Decodes funct3, checks legality/alignment/range, extends
//            sub-word loads and performs sub-word stores as read-modify-write.
// Ports    : clk, rst_n                   clock / async active-low reset
//            req_valid/ready/we/funct3/addr/wdata   core request channel
//            resp_valid/err/rdata         core response (one-cycle pulse)
//            mem_addr/wdata/we/re/rdata   data memory port
// Revision : 1.0  initial release
// ============================================================================
module lsu_mem_ctrl #(
  parameter int MEM_WORDS = 8192,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata
);

  // One extra bit so the byte size of the memory never wraps.
  localparam logic [ADDR_W:0] C_MEM_BYTES = (ADDR_W+1)'(MEM_WORDS) << 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t      r_state;
  logic [1:0]  r_off;        // byte offset inside the word
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [15:0] r_wdata;      // only the B/H lanes are needed after accept
  logic        r_err;
  logic [31:0] r_rdata;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  logic        w_illegal;
  logic        w_misalign;
  logic        w_range_err;
  logic        w_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;
  logic [31:0] w_merged;

  // Request checks, evaluated on the live request while in IDLE.
  assign w_illegal   = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                       (req_we && req_funct3[2]);
  assign w_misalign  = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_range_err = ({1'b0, req_addr} >= C_MEM_BYTES);
  assign w_err       = w_illegal || w_misalign || w_range_err;

  // Lane extraction / extension for loads and lane merge for sub-word stores.
  always_comb begin
    w_byte     = 8'h00;
    w_half     = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_load_ext = mem_rdata;
    w_merged   = mem_rdata;
    case (r_off)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_ext = {24'h0, w_byte};
      3'b101:  w_load_ext = {16'h0, w_half};
      default: w_load_ext = mem_rdata;
    endcase
    if (r_funct3[1:0] == 2'b00) begin
      case (r_off)
        2'd0:    w_merged[7:0]   = r_wdata[7:0];
        2'd1:    w_merged[15:8]  = r_wdata[7:0];
        2'd2:    w_merged[23:16] = r_wdata[7:0];
        default: w_merged[31:24] = r_wdata[7:0];
      endcase
    end else if (r_off[1]) begin
      w_merged[31:16] = r_wdata;
    end else begin
      w_merged[15:0] = r_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_off       <= 2'b00;
      r_we        <= 1'b0;
      r_funct3    <= 3'b000;
      r_wdata     <= 16'h0;
      r_err       <= 1'b0;
      r_rdata     <= 32'h0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_off      <= req_addr[1:0];
            r_we       <= req_we;
            r_funct3   <= req_funct3;
            r_wdata    <= req_wdata[15:0];
            r_mem_addr <= 32'({req_addr[ADDR_W-1:2], 2'b00});
            if (w_err) begin
              // Errors skip the memory entirely; rdata reads 0 with the pulse.
              r_err   <= 1'b1;
              r_rdata <= 32'h0;
              r_state <= ST_RESP;
            end else begin
              r_err <= 1'b0;
              if (req_we && (req_funct3[1:0] == 2'b10)) begin
                r_mem_wdata <= req_wdata;
                r_state     <= ST_WRITE;
              end else begin
                r_state <= ST_READ;
              end
            end
          end
        end
        ST_READ: begin
          if (r_we) begin
            r_mem_wdata <= w_merged;
            r_state     <= ST_WRITE;
          end else begin
            r_rdata <= w_load_ext;
            r_state <= ST_RESP;
          end
        end
        ST_WRITE: begin
          r_rdata <= 32'h0;
          r_state <= ST_RESP;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so reset removes them without a clock.
  assign req_ready  = (r_state == ST_IDLE);
  assign mem_re     = (r_state == ST_READ);
  assign mem_we     = (r_state == ST_WRITE);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_err   = (r_state == ST_RESP) && r_err;
  assign resp_rdata = r_rdata;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_ctrl
// Purpose  : Self-checking bench for lsu_mem_ctrl: directed cases, reset
//            during a write, handshake behaviour and randomized traffic
//            checked against an array-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_lsu_mem_ctrl;

  localparam int MEM_WORDS = 8192;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem     [0:MEM_WORDS-1];
  logic [31:0] ref_mem [0:MEM_WORDS-1];

  logic        pre_en = 1'b0;
  logic [12:0] pre_idx = '0;
  logic [31:0] pre_data = '0;

  lsu_mem_ctrl #(.MEM_WORDS(MEM_WORDS), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, write on posedge, plus a preload port.
  assign mem_rdata = (mem_re && mem_addr < 32'h8000) ? mem[mem_addr[14:2]] : 32'h0;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[14:2]] <= mem_wdata;
    else if (pre_en) mem[pre_idx] <= pre_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] data);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = 13'(idx); pre_data = data;
    @(posedge clk); #1;
    pre_en = 1'b0;
    ref_mem[idx] = data;
  endtask

  // Reference model: derives the whole outcome of one access from the ISA rules.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic err, output logic [31:0] lat,
                       output logic [31:0] re_n, output logic [31:0] we_n,
                       output logic [31:0] rdata, output logic [31:0] newword);
    int size, off, idx;
    logic is_signed, illegal, mis, oor;
    logic [31:0] word, v, mask;
    illegal   = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && (f3 == 4 || f3 == 5));
    size      = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : 4;
    is_signed = (f3 == 0 || f3 == 1);
    mis       = (a % size) != 0;
    oor       = a >= 32'(MEM_WORDS * 4);
    err       = illegal || mis || oor;
    rdata = 0; newword = 0; lat = 1; re_n = 0; we_n = 0;
    if (!err) begin
      idx  = int'(a / 4);
      off  = int'(a % 4);
      word = ref_mem[idx];
      if (!we) begin
        lat = 2; re_n = 1;
        if (size == 4) v = word;
        else begin
          v = (word >> (8 * off)) % (32'd1 << (8 * size));
          if (is_signed && v >= (32'd1 << (8 * size - 1))) v = v - (32'd1 << (8 * size));
        end
        rdata = v;
      end else begin
        we_n = 1;
        if (size == 4) begin
          lat = 2; newword = wd;
        end else begin
          lat = 3; re_n = 1;
          mask    = ((32'd1 << (8 * size)) - 1) << (8 * off);
          newword = (word & ~mask) | ((wd << (8 * off)) & mask);
        end
      end
    end
  endtask

  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] got);
    logic        e_err, g_err, done, leak;
    logic [31:0] e_lat, e_re, e_we, e_rdata, e_word;
    logic [31:0] lat, re_n, we_n, wr_addr, wr_data;
    int w;
    model(we, f3, a, wd, e_err, e_lat, e_re, e_we, e_rdata, e_word);
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 10) begin @(negedge clk); w++; end
    check("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    // Scramble the request lines: the DUT must work from its latched copy.
    req_valid = 1'b0; req_we = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7)); req_addr = $urandom; req_wdata = $urandom;
    lat = 1; re_n = 0; we_n = 0; done = 0; leak = 0; g_err = 0; got = 0;
    wr_addr = 0; wr_data = 0;
    while (!done && lat <= 8) begin
      if (mem_re) re_n++;
      if (mem_we) begin we_n++; wr_addr = mem_addr; wr_data = mem_wdata; end
      if (resp_valid) begin
        done = 1; got = resp_rdata; g_err = resp_err;
      end else begin
        if (resp_err) leak = 1;
        @(posedge clk); #1; lat++;
      end
    end
    check("resp_seen", 32'(done), 32'd1);
    check("latency", lat, e_lat);
    check("resp_err", 32'(g_err), 32'(e_err));
    check("resp_rdata", got, e_rdata);
    check("mem_re_cycles", re_n, e_re);
    check("mem_we_cycles", we_n, e_we);
    check("err_without_valid", 32'(leak), 32'd0);
    if (e_we != 0) begin
      check("mem_wr_addr", wr_addr, {a[31:2], 2'b00});
      check("mem_wr_data", wr_data, e_word);
      ref_mem[a[14:2]] = e_word;
    end
    @(posedge clk); #1;
    check("resp_pulse_once", 32'(resp_valid), 32'd0);
    check("rdata_hold", resp_rdata, got);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] got;
    logic        rw;
    logic [2:0]  f;
    logic [31:0] ad;
    rst_n = 1'b0; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Window 0x100..0x17F plus the last word of memory.
    for (int i = 64; i < 96; i++) poke(i, $urandom);
    poke(64, 32'h8899AABB);
    poke(MEM_WORDS - 1, 32'h13579BDF);

    run_txn(0, 3'b000, 32'h101, 0, got); check("LB_0x101", got, 32'hFFFFFFAA);
    run_txn(0, 3'b100, 32'h101, 0, got); check("LBU_0x101", got, 32'h000000AA);
    run_txn(0, 3'b001, 32'h102, 0, got); check("LH_0x102", got, 32'hFFFF8899);
    run_txn(0, 3'b101, 32'h100, 0, got); check("LHU_0x100", got, 32'h0000AABB);
    run_txn(1, 3'b000, 32'h103, 32'h12345678, got);
    run_txn(0, 3'b010, 32'h100, 0, got); check("LW_after_SB", got, 32'h7899AABB);
    run_txn(1, 3'b010, 32'h104, 32'hDEADBEEF, got);
    run_txn(0, 3'b010, 32'h104, 0, got); check("LW_after_SW", got, 32'hDEADBEEF);
    run_txn(1, 3'b001, 32'h106, 32'hCAFE1234, got);
    run_txn(0, 3'b010, 32'h104, 0, got); check("LW_after_SH", got, 32'h1234BEEF);
    run_txn(0, 3'b010, 32'h102, 0, got);   // misaligned LW
    run_txn(1, 3'b001, 32'h101, 0, got);   // misaligned SH
    run_txn(0, 3'b011, 32'h100, 0, got);   // illegal funct3
    run_txn(1, 3'b100, 32'h100, 0, got);   // unsigned store is illegal
    run_txn(0, 3'b010, 32'h8000, 0, got);  // first out-of-range byte
    run_txn(0, 3'b010, 32'h7FFC, 0, got); check("LW_last_word", got, 32'h13579BDF);

    // Reset while the sub-word store sits in its write cycle.
    poke(64, 32'h8899AABB);
    @(negedge clk);
    req_valid = 1; req_we = 1; req_funct3 = 3'b000; req_addr = 32'h100; req_wdata = 32'h11;
    @(posedge clk); #1; req_valid = 0;
    @(posedge clk); #1;
    check("rst_mid_we_before", 32'(mem_we), 32'd1);
    #2; rst_n = 1'b0; #1;
    check("rst_mid_we_drop", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    check("rst_mid_mem_kept", mem[64], 32'h8899AABB);
    check("rst_mid_no_resp", 32'(resp_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    check("rst_mid_no_resp2", 32'(resp_valid), 32'd0);
    check("rst_mid_rdata", resp_rdata, 32'd0);

    // Handshake: req_valid held with moving address during a busy load.
    poke(64, 32'h11111111); poke(65, 32'h22222222);
    poke(66, 32'h33333333); poke(67, 32'h44444444);
    @(negedge clk);
    req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h100;
    @(posedge clk); #1;
    check("hs_busy_ready", 32'(req_ready), 32'd0);
    @(negedge clk); req_addr = 32'h104;
    @(posedge clk); #1;
    check("hs_first_valid", 32'(resp_valid), 32'd1);
    check("hs_first_data", resp_rdata, ref_mem[64]);
    @(negedge clk); req_addr = 32'h108;
    @(posedge clk); #1;
    check("hs_idle_ready", 32'(req_ready), 32'd1);
    @(negedge clk); req_addr = 32'h10C;
    @(posedge clk); #1; req_valid = 0;
    check("hs_second_accepted", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("hs_second_valid", 32'(resp_valid), 32'd1);
    check("hs_second_data", resp_rdata, ref_mem[67]);

    // Randomized traffic in the preloaded window, with some out-of-range hits.
    for (int i = 0; i < 300; i++) begin
      rw = 1'($urandom_range(0, 1));
      f  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) ad = $urandom | 32'h8000_0000;
      else ad = 32'h100 + 32'($urandom_range(0, 127));
      run_txn(rw, f, ad, $urandom, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
